// File: rtl/soma_input_arbiter.sv
// soma_input_arbiter: round-robin arbiter and timestep sequencer feeding one shared soma datapath
// Ports: clk, rst (async, active-low), kill (sync, permanent until reset), step_start (opens a timestep),
//   req_valid/req_weight/req_ready (per-requester spikes, one-hot accept), o_valid/o_weight/o_src/o_ready
//   (single-entry output register with handshake), step_done (timestep drained pulse), busy (in ARB).
// Optional: define SOMA_ARB_STALL_CNT_EN to add stall_cnt[15:0], a saturating count of stalled ARB cycles.
module soma_input_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2,
  parameter int W_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   kill,
  input  logic                   step_start,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*W_W-1:0]   req_weight,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   o_valid,
  output logic [W_W-1:0]         o_weight,
  output logic [IDX_W-1:0]       o_src,
  input  logic                   o_ready,
  output logic                   step_done,
  output logic                   busy
`ifdef SOMA_ARB_STALL_CNT_EN
  , output logic [15:0]          stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ARB, KILLED} state_t;
  state_t state;
  logic [IDX_W-1:0] ptr, gidx;
  logic found, free, grant, drain;
  // lowest offset from ptr wins, so scan offsets downward and let the last hit stand
  always_comb begin
    gidx = '0;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % N_REQ]) begin
        gidx = IDX_W'((int'(ptr) + k) % N_REQ);
        found = 1'b1;
      end
  end
  assign free  = !o_valid || o_ready;
  assign grant = state == ARB && !kill && free && found;
  assign drain = state == ARB && !(|req_valid) && free;
  assign busy  = state == ARB;
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gidx] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      o_valid   <= 1'b0;
      o_weight  <= '0;
      o_src     <= '0;
      step_done <= 1'b0;
    end else if (kill || state == KILLED) begin
      state     <= KILLED;
      o_valid   <= 1'b0;
      step_done <= 1'b0;
    end else begin
      step_done <= drain;
      if (grant) begin
        o_valid  <= 1'b1;
        o_weight <= req_weight[gidx*W_W +: W_W];
        o_src    <= gidx;
        ptr      <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      end else if (o_ready) o_valid <= 1'b0;
      if (drain) state <= IDLE;
      else if (state == IDLE && step_start) state <= ARB;
    end
`ifdef SOMA_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (!kill && state == IDLE && step_start) stall_cnt <= '0;
    else if (!kill && state == ARB && o_valid && !o_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule
